pipe3_shift: RTL and testbench
==============================

// Module: pipe3_shift
// PURPOSE
//  3-stage registered data pipeline with valid/ready handshake on both ends; the
//  sink-side counterpart to our stimulus benches, which drive in_* and consume out_*.
//  Exposes per-stage taps f/g/h for waveform inspection of register-transfer ordering.
//  All stages update together from pre-edge values, with no stage reading a same-edge update.
//  Bubbles collapse: an empty stage fills even when the output is stalled.
// PARAMETERS
//  WIDTH   4   data width of every stage, tap and port
//  CNTW    8   width of the delivered-beat counter
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-low reset (0 = reset asserted)
//  in_valid   in   1      upstream has a beat on in_data
//  in_ready   out  1      pipe accepts in_data this cycle
//  in_data    in   WIDTH  upstream beat
//  out_valid  out  1      stage 2 holds a beat
//  out_ready  in   1      downstream accepts out_data this cycle
//  out_data   out  WIDTH  beat held in stage 2 (== h)
//  f          out  WIDTH  stage-0 data tap
//  g          out  WIDTH  stage-1 data tap
//  h          out  WIDTH  stage-2 data tap
//  occupancy  out  2      number of valid stages, 0..3
//  delivered  out  CNTW   count of beats delivered on the output (wraps)
// BEHAVIOUR
//  - Reset (reset==0, async, regardless of clk): v0,v1,v2=0; f,g,h=0; delivered=0;
//    occupancy=0; out_valid=0; in_ready=1 combinationally while in reset is don't-care,
//    but no beat is accepted while reset==0. First active edge follows reset release.
//  - Transfer in: in_valid & in_ready at a rising edge. Transfer out: out_valid & out_ready.
//  - Advance terms (combinational, from current state):
//    adv2 = out_ready | ~v2;  adv1 = adv2 | ~v1... precisely: s2 loads when adv2;
//    s1 moves when ~v2 | out_ready; s1 may load when ~v1 | (s1 moves);
//    s0 moves when s1 may load; in_ready = ~v0 | (s0 moves).
//  - On each edge, in parallel from pre-edge values:
//    s2 <= s1 if (s1 moves & v1); v2 <= v1 if s2 loads, else v2 & ~out_ready.
//    s1 <= s0 if (s0 moves & v0); v1 <= v0 if s1 loads.
//    s0 <= in_data on transfer in; v0 <= in_valid if s0 loads.
//  - Data regs of an invalid stage hold their last value (not cleared) except at reset.
//  - Latency: beat accepted at edge k into empty pipe -> out_valid=1, h=beat after edge k+2.
//  - Throughput: 1 beat/cycle when out_ready stays high; no combinational path
//    in_valid->out_valid; out_ready->in_ready path is permitted (ripple through advance).
//  - Full (occupancy 3) & out_ready=0: in_ready=0, all stages hold, taps stable.
//  - Full & out_ready=1 & in_valid=1: simultaneous in and out, occupancy stays 3.
//  - Empty: out_valid=0; out_ready ignored; delivered unchanged.
//  - out_data stable while out_valid & ~out_ready (no change until accepted).
//  - delivered += 1 on each transfer out, wraps 2^CNTW-1 -> 0.
//  - occupancy = v0+v1+v2, registered-state derived (combinational sum).
//  - Reset asserted mid-stream: all in-flight beats dropped immediately, counter cleared.
// TESTING
//  1 Reset: hold reset=0 with in_valid=1,in_data=4'h5, 3 edges -> f=g=h=0, out_valid=0,
//    delivered=0; release -> in_ready=1.
//  2 Latency: send 4'h1 at edge k, out_ready=1 -> f=1 after k, g=1 after k+1, h=1 and
//    out_valid=1 after k+2; delivered=1 after k+3.
//  3 Streaming: 1,2,3,4,5 back-to-back, out_ready=1 -> out_data 1..5 on consecutive
//    cycles, in_ready never drops, occupancy settles at 3.
//  4 Stall/collapse: send A,B with out_ready=0 -> A in s2,B in s1 (bubble collapsed),
//    occupancy=2; third beat C -> occupancy=3, in_ready=0; 4th beat waits until out_ready=1.
//  5 Full simultaneous: full pipe, in_valid=1,out_ready=1 for 4 cycles -> occupancy=3
//    throughout, 4 out transfers, ordering preserved.
//  6 Wrap + mid-reset: CNTW=8, deliver 256 beats -> delivered=0; then reset=0 with 3
//    beats in flight -> occupancy=0 immediately, nothing further emerges.

Source files
------------

// File: rtl/pipe3_shift_if.sv
// Handshake bundle for pipe3_shift: upstream in_* and downstream out_* channels.
interface pipe3_shift_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  // pipe side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  // bench / surrounding logic side
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe3_shift.sv
// Three-stage registered pipeline with valid/ready on both ends. Empty stages
// fill even while the output stalls, so bubbles collapse toward stage 2.
module pipe3_shift #(
  parameter int WIDTH = 4,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             reset,
  pipe3_shift_if.slave     io,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] h,
  output logic [1:0]       occupancy,
  output logic [CNTW-1:0]  delivered
);

  logic [2:0]            vld_q, vld_d;
  logic [2:0][WIDTH-1:0] dat_q, dat_d;
  logic [CNTW-1:0]       del_q, del_d;
  logic                  adv2, ld1, ld0;

  // Advance terms ripple back from the output; all next-state from pre-edge values
  always_comb begin
    adv2  = io.out_ready | ~vld_q[2];
    ld1   = ~vld_q[1] | adv2;
    ld0   = ~vld_q[0] | ld1;
    vld_d = vld_q;
    dat_d = dat_q;
    del_d = del_q;
    if (adv2) begin
      vld_d[2] = vld_q[1];
      if (vld_q[1]) dat_d[2] = dat_q[1];
    end else begin
      vld_d[2] = vld_q[2] & ~io.out_ready;
    end
    if (ld1) begin
      vld_d[1] = vld_q[0];
      if (vld_q[0]) dat_d[1] = dat_q[0];
    end
    if (ld0) begin
      vld_d[0] = io.in_valid;
      if (io.in_valid) dat_d[0] = io.in_data;
    end
    if (vld_q[2] & io.out_ready) del_d = del_q + 1'b1;
  end

  // State registers; reset drops all in-flight beats immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      dat_q <= '0;
      del_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
      del_q <= del_d;
    end
  end

  // Outputs derived from registered state
  always_comb begin
    io.in_ready  = ld0;
    io.out_valid = vld_q[2];
    io.out_data  = dat_q[2];
    f            = dat_q[0];
    g            = dat_q[1];
    h            = dat_q[2];
    occupancy    = {1'b0, vld_q[0]} + {1'b0, vld_q[1]} + {1'b0, vld_q[2]};
    delivered    = del_q;
  end

endmodule

// File: tb/tb_pipe3_shift.sv
// Scoreboarded bench for pipe3_shift: directed scenarios plus random traffic.
module tb_pipe3_shift;
  localparam int WIDTH = 4;
  localparam int CNTW  = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] f, g, h;
  logic [1:0]       occupancy;
  logic [CNTW-1:0]  delivered;

  pipe3_shift_if #(.WIDTH(WIDTH)) bus ();

  pipe3_shift #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .io(bus),
    .f(f), .g(g), .h(h), .occupancy(occupancy), .delivered(delivered)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of accepted beats and a delivered counter
  logic [WIDTH-1:0] sb_q[$];
  int               mdl_del = 0;
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;

  // Monitor on the falling edge: inputs and outputs are stable here
  always @(negedge clk) begin
    if (!reset) begin
      sb_q.delete();
      mdl_del    = 0;
      prev_stall = 1'b0;
    end else begin
      chk("occupancy", 32'(occupancy), 32'(sb_q.size()));
      chk("delivered", 32'(delivered), 32'(mdl_del % (1 << CNTW)));
      chk("in_ready", 32'(bus.in_ready), 32'((sb_q.size() < 3) || bus.out_ready));
      if (prev_stall) begin
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_data", 32'(bus.out_data), 32'(prev_data));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL spurious_out: got %0h expected no beat", bus.out_data);
        end else begin
          chk("out_data", 32'(bus.out_data), 32'(sb_q.pop_front()));
          mdl_del++;
        end
      end
      if (bus.in_valid && bus.in_ready) sb_q.push_back(bus.in_data);
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
  endtask

  initial begin
    int need;
    reset = 1'b0;
    drive(1'b1, 4'h5, 1'b0);
    // 1 reset holds everything cleared despite in_valid
    repeat (3) @(posedge clk);
    #1;
    chk("rst_f", 32'(f), 32'd0);
    chk("rst_g", 32'(g), 32'd0);
    chk("rst_h", 32'(h), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_delivered", 32'(delivered), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    drive(1'b0, 4'h0, 1'b0);
    reset = 1'b1;
    #1;
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);
    step();

    // 2 latency
    drive(1'b1, 4'h1, 1'b1);
    step();
    drive(1'b0, 4'h0, 1'b1);
    chk("lat_f", 32'(f), 32'd1);
    chk("lat_ov0", 32'(bus.out_valid), 32'd0);
    step();
    chk("lat_g", 32'(g), 32'd1);
    chk("lat_ov1", 32'(bus.out_valid), 32'd0);
    step();
    chk("lat_h", 32'(h), 32'd1);
    chk("lat_ov2", 32'(bus.out_valid), 32'd1);
    chk("lat_del_pre", 32'(delivered), 32'd0);
    step();
    chk("lat_del", 32'(delivered), 32'd1);
    step(2);

    // 3 streaming
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 4'(i), 1'b1);
      chk("str_in_ready", 32'(bus.in_ready), 32'd1);
      step();
      if (i >= 3) chk("str_occ", 32'(occupancy), 32'd3);
    end
    drive(1'b0, 4'h0, 1'b1);
    step(4);

    // 4 stall and bubble collapse
    drive(1'b1, 4'hA, 1'b0); step();
    drive(1'b1, 4'hB, 1'b0); step();
    drive(1'b0, 4'h0, 1'b0); step();
    chk("col_h", 32'(h), 32'hA);
    chk("col_g", 32'(g), 32'hB);
    chk("col_occ", 32'(occupancy), 32'd2);
    drive(1'b1, 4'hC, 1'b0); step();
    chk("full_occ", 32'(occupancy), 32'd3);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 4'hD, 1'b0); step(2);
    chk("full_hold_h", 32'(h), 32'hA);
    chk("full_hold_rdy", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    #1;
    chk("ripple_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    // 5 full with simultaneous in/out
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'(14 + i), 1'b1);
      step();
      chk("simul_occ", 32'(occupancy), 32'd3);
    end
    drive(1'b0, 4'h0, 1'b1);
    step(4);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0));
      step();
    end
    drive(1'b0, 4'h0, 1'b1);
    step(5);

    // 6 counter wrap
    need = (256 - (mdl_del % 256)) % 256;
    for (int i = 0; i < need; i++) begin
      drive(1'b1, 4'($urandom_range(0, 15)), 1'b1);
      step();
    end
    drive(1'b0, 4'h0, 1'b1);
    step(4);
    chk("wrap_delivered", 32'(delivered), 32'd0);

    // mid-stream reset
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'(3 + i), 1'b0);
      step();
    end
    drive(1'b0, 4'h0, 1'b0);
    chk("pre_rst_occ", 32'(occupancy), 32'd3);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_occ", 32'(occupancy), 32'd0);
    chk("mid_rst_ov", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_del", 32'(delivered), 32'd0);
    step(2);
    reset = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("post_rst_ov", 32'(bus.out_valid), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
